// File: rtl/forwarding_scoreboard.sv
// Operand forwarding across prioritised result stages, combined with a per-register
// countdown scoreboard that stalls reads of multi-cycle results not yet forwardable.
module forwarding_scoreboard #(
   parameter int DATA_SIZE  = 32,
   parameter int GPR_SIZE   = 3,
   parameter int READ_PORTS = 2,
   parameter int STAGES     = 2,
   parameter int LAT_W      = 3,
   parameter int ZERO_REG   = 1,
   parameter int CNT_W      = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            flush,
   input  logic                            issue_valid,
   input  logic [GPR_SIZE-1:0]             issue_dest,
   input  logic [LAT_W-1:0]                issue_latency,
   input  logic [STAGES-1:0]               fwd_valid,
   input  logic [STAGES*GPR_SIZE-1:0]      fwd_dest,
   input  logic [STAGES*DATA_SIZE-1:0]     fwd_result,
   input  logic [READ_PORTS-1:0]           rd_valid,
   input  logic [READ_PORTS*GPR_SIZE-1:0]  rd_addr,
   input  logic [READ_PORTS*DATA_SIZE-1:0] rd_operand,
   output logic [READ_PORTS*DATA_SIZE-1:0] result,
   output logic                            stall,
   output logic [2**GPR_SIZE-1:0]          busy_mask,
   output logic [CNT_W-1:0]                stall_count
);

   localparam int NREGS = 2**GPR_SIZE;

   logic [LAT_W-1:0] cnt [NREGS];
   logic [NREGS-1:0] pending;
   logic             issue_accept;

   always_comb begin
      for (int r = 0; r < NREGS; r++) pending[r] = (cnt[r] != '0);
      if (ZERO_REG != 0) pending[0] = 1'b0;
   end

   assign busy_mask = pending;

   always_comb begin
      stall = 1'b0;
      for (int p = 0; p < READ_PORTS; p++)
         if (rd_valid[p] && pending[rd_addr[p*GPR_SIZE +: GPR_SIZE]]) stall = 1'b1;
   end

   // A stalled issue is being held upstream, so it must not touch the scoreboard yet.
   assign issue_accept = issue_valid && !stall && (issue_latency != '0) &&
                         !((ZERO_REG != 0) && (issue_dest == '0));

   for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
      logic [GPR_SIZE-1:0]  addr;
      logic [DATA_SIZE-1:0] res;

      assign addr = rd_addr[p*GPR_SIZE +: GPR_SIZE];

      // Walk from oldest to youngest so the lowest-index matching stage wins.
      always_comb begin
         res = rd_operand[p*DATA_SIZE +: DATA_SIZE];
         for (int i = STAGES-1; i >= 0; i--)
            if (fwd_valid[i] && (fwd_dest[i*GPR_SIZE +: GPR_SIZE] == addr))
               res = fwd_result[i*DATA_SIZE +: DATA_SIZE];
         if ((ZERO_REG != 0) && (addr == '0)) res = '0;
      end

      assign result[p*DATA_SIZE +: DATA_SIZE] = res;
   end

   // The issue write comes last so a new latency overrides the same-register decrement.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      end else if (flush) begin
         for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++)
            if (cnt[r] != '0) cnt[r] <= cnt[r] - LAT_W'(1);
         if (issue_accept) cnt[issue_dest] <= issue_latency;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         stall_count <= '0;
      else if (stall && (stall_count != '1))
         stall_count <= stall_count + CNT_W'(1);
   end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed self-checking bench for forwarding_scoreboard with default parameters
// (32-bit data, 8 registers, 2 read ports, 2 forwarding stages).
module tb_forwarding_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        issue_valid;
   logic [2:0]  issue_dest;
   logic [2:0]  issue_latency;
   logic [1:0]  fwd_valid;
   logic [5:0]  fwd_dest;
   logic [63:0] fwd_result;
   logic [1:0]  rd_valid;
   logic [5:0]  rd_addr;
   logic [63:0] rd_operand;
   logic [63:0] result;
   logic        stall;
   logic [7:0]  busy_mask;
   logic [15:0] stall_count;

   int n_checks = 0;
   int n_fail   = 0;

   forwarding_scoreboard dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_latency(issue_latency),
      .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_result(fwd_result),
      .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_operand(rd_operand),
      .result(result), .stall(stall), .busy_mask(busy_mask), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   // Inputs change on the falling edge; checks run #1 later, well away from posedge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      flush = 1'b0; issue_valid = 1'b0; issue_dest = '0; issue_latency = '0;
      fwd_valid = '0; fwd_dest = '0; fwd_result = '0;
      rd_valid = '0; rd_addr = '0; rd_operand = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      rd_valid = 2'b11;
      rd_addr = {3'd2, 3'd1};
      rd_operand = {32'h2222_2222, 32'h1111_1111};
      @(negedge clk);
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall: got %0b expected 0", stall); end
      n_checks++;
      if (busy_mask !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_busy: got %h expected 00", busy_mask); end
      n_checks++;
      if (stall_count !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", stall_count); end
      n_checks++;
      if (result !== 64'h2222_2222_1111_1111) begin n_fail++; $display("[TB] FAIL reset_result: got %h expected 2222222211111111", result); end
   endtask

   task automatic test_priority();
      idle_inputs();
      rd_valid = 2'b01;
      rd_addr = {3'd0, 3'd5};
      rd_operand = {32'h0, 32'h0000_DEAD};
      fwd_dest = {3'd5, 3'd5};
      fwd_result = {32'h0000_BBBB, 32'h0000_AAAA};
      fwd_valid = 2'b11;
      #1;
      n_checks++;
      if (result[31:0] !== 32'h0000_AAAA) begin n_fail++; $display("[TB] FAIL prio_both: got %h expected 0000aaaa", result[31:0]); end
      fwd_valid = 2'b10;
      #1;
      n_checks++;
      if (result[31:0] !== 32'h0000_BBBB) begin n_fail++; $display("[TB] FAIL prio_stage1: got %h expected 0000bbbb", result[31:0]); end
      fwd_valid = 2'b00;
      #1;
      n_checks++;
      if (result[31:0] !== 32'h0000_DEAD) begin n_fail++; $display("[TB] FAIL prio_none: got %h expected 0000dead", result[31:0]); end
      // Port 1 reading r5 must also pick stage 0, independently of port 0.
      fwd_valid = 2'b11;
      rd_addr = {3'd5, 3'd1};
      rd_operand = {32'h0000_0001, 32'h0000_0002};
      #1;
      n_checks++;
      if (result !== 64'h0000_AAAA_0000_0002) begin n_fail++; $display("[TB] FAIL prio_port1: got %h expected 0000aaaa00000002", result); end
      @(negedge clk);
   endtask

   task automatic test_load_latency();
      idle_inputs();
      issue_valid = 1'b1; issue_dest = 3'd3; issue_latency = 3'd2;
      tick();
      idle_inputs();
      rd_valid = 2'b10;
      rd_addr = {3'd3, 3'd0};
      #1;
      n_checks++;
      if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL load_stall_t1: got %0b expected 1", stall); end
      n_checks++;
      if (busy_mask !== 8'h08) begin n_fail++; $display("[TB] FAIL load_busy_t1: got %h expected 08", busy_mask); end
      tick();
      #1;
      n_checks++;
      if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL load_stall_t2: got %0b expected 1", stall); end
      tick();
      #1;
      n_checks++;
      if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL load_stall_t3: got %0b expected 0", stall); end
      n_checks++;
      if (busy_mask !== 8'h00) begin n_fail++; $display("[TB] FAIL load_busy_t3: got %h expected 00", busy_mask); end
      n_checks++;
      if (stall_count !== 16'd2) begin n_fail++; $display("[TB] FAIL load_count: got %0d expected 2", stall_count); end
   endtask

   task automatic test_waw();
      idle_inputs();
      issue_valid = 1'b1; issue_dest = 3'd4; issue_latency = 3'd1;
      tick();
      issue_latency = 3'd3;
      tick();
      idle_inputs();
      for (int k = 1; k <= 3; k++) begin
         #1;
         n_checks++;
         if (busy_mask[4] !== 1'b1) begin n_fail++; $display("[TB] FAIL waw_busy_c%0d: got %0b expected 1", k, busy_mask[4]); end
         tick();
      end
      #1;
      n_checks++;
      if (busy_mask !== 8'h00) begin n_fail++; $display("[TB] FAIL waw_busy_end: got %h expected 00", busy_mask); end
      // An issue presented while stalled must leave the scoreboard alone.
      issue_valid = 1'b1; issue_dest = 3'd1; issue_latency = 3'd2;
      tick();
      rd_valid = 2'b01; rd_addr = {3'd0, 3'd1};
      issue_dest = 3'd5; issue_latency = 3'd4;
      #1;
      n_checks++;
      if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL waw_gate_stall: got %0b expected 1", stall); end
      tick();
      issue_valid = 1'b0;
      #1;
      n_checks++;
      if (busy_mask !== 8'h02) begin n_fail++; $display("[TB] FAIL waw_gate_busy: got %h expected 02", busy_mask); end
      tick();
      #1;
      n_checks++;
      if (busy_mask !== 8'h00) begin n_fail++; $display("[TB] FAIL waw_gate_clear: got %h expected 00", busy_mask); end
      n_checks++;
      if (stall_count !== 16'd4) begin n_fail++; $display("[TB] FAIL waw_count: got %0d expected 4", stall_count); end
   endtask

   task automatic test_zero_reg();
      idle_inputs();
      issue_valid = 1'b1; issue_dest = 3'd0; issue_latency = 3'd5;
      rd_valid = 2'b01; rd_addr = {3'd0, 3'd0};
      rd_operand = {32'h0, 32'h0000_5555};
      fwd_valid = 2'b01; fwd_dest = {3'd0, 3'd0}; fwd_result = {32'h0, 32'h0000_1234};
      #1;
      n_checks++;
      if (result[31:0] !== 32'h0) begin n_fail++; $display("[TB] FAIL zero_result: got %h expected 00000000", result[31:0]); end
      tick();
      issue_valid = 1'b0;
      #1;
      n_checks++;
      if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_stall: got %0b expected 0", stall); end
      n_checks++;
      if (busy_mask !== 8'h00) begin n_fail++; $display("[TB] FAIL zero_busy: got %h expected 00", busy_mask); end
      n_checks++;
      if (result[31:0] !== 32'h0) begin n_fail++; $display("[TB] FAIL zero_result_t1: got %h expected 00000000", result[31:0]); end
   endtask

   task automatic test_flush();
      idle_inputs();
      issue_valid = 1'b1; issue_dest = 3'd2; issue_latency = 3'd7;
      tick();
      issue_dest = 3'd6;
      tick();
      issue_valid = 1'b0;
      rd_valid = 2'b10; rd_addr = {3'd6, 3'd0};
      #1;
      n_checks++;
      if (busy_mask !== 8'h44) begin n_fail++; $display("[TB] FAIL flush_pre_busy: got %h expected 44", busy_mask); end
      n_checks++;
      if (stall !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_pre_stall: got %0b expected 1", stall); end
      // Issue during the flush cycle is dropped even though nothing stalls.
      rd_valid = 2'b00;
      flush = 1'b1;
      issue_valid = 1'b1; issue_dest = 3'd3; issue_latency = 3'd3;
      tick();
      idle_inputs();
      rd_valid = 2'b10; rd_addr = {3'd6, 3'd0};
      #1;
      n_checks++;
      if (busy_mask !== 8'h00) begin n_fail++; $display("[TB] FAIL flush_busy: got %h expected 00", busy_mask); end
      n_checks++;
      if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_stall: got %0b expected 0", stall); end
      n_checks++;
      if (stall_count !== 16'd4) begin n_fail++; $display("[TB] FAIL flush_count: got %0d expected 4", stall_count); end
   endtask

   task automatic test_saturation();
      // Reset in the middle of a pending load must leave nothing behind.
      idle_inputs();
      issue_valid = 1'b1; issue_dest = 3'd7; issue_latency = 3'd7;
      tick();
      issue_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      rd_valid = 2'b01; rd_addr = {3'd0, 3'd7};
      #1;
      n_checks++;
      if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_stall: got %0b expected 0", stall); end
      n_checks++;
      if (busy_mask !== 8'h00) begin n_fail++; $display("[TB] FAIL midreset_busy: got %h expected 00", busy_mask); end
      n_checks++;
      if (stall_count !== 16'd0) begin n_fail++; $display("[TB] FAIL midreset_count: got %0d expected 0", stall_count); end
      // Reading r6 while re-issuing it with latency 7: 7 stalled edges per 8.
      rd_addr = {3'd0, 3'd6};
      issue_valid = 1'b1; issue_dest = 3'd6; issue_latency = 3'd7;
      repeat (8 * 9362) @(posedge clk);
      #1;
      n_checks++;
      if (stall_count !== 16'hFFFE) begin n_fail++; $display("[TB] FAIL sat_pre: got %h expected fffe", stall_count); end
      repeat (16) @(posedge clk);
      #1;
      n_checks++;
      if (stall_count !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL sat_hold: got %h expected ffff", stall_count); end
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_priority();
      test_load_latency();
      test_waw();
      test_zero_reg();
      test_flush();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/forwarding_scoreboard.md
Name: forwarding_scoreboard

Overview:
- Parametrised successor to the pipeline operand-forwarding logic.
- Resolves N read ports against M prioritised forwarding stages.
- Tracks in-flight multi-cycle results (loads, multiplies) in a per-register countdown scoreboard, and raises a stall when a read targets a result that is not yet forwardable.
- Sits between the register read stage and execute. Also keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
DATA_SIZE, 32, operand/result width
GPR_SIZE, 3, register address width; NREGS = 2**GPR_SIZE
READ_PORTS, 2, number of operand read ports
STAGES, 2, number of forwarding sources; index 0 = youngest (highest priority)
LAT_W, 3, width of latency field/counters
ZERO_REG, 1, 1 = register 0 is hardwired zero, never pending/forwarded
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous, active-low reset
flush  in  1  clears scoreboard next edge
issue_valid  in  1  instruction issuing this cycle writes issue_dest
issue_dest  in  GPR_SIZE  destination register of issuing instruction
issue_latency  in  LAT_W  cycles until result reaches a forwarding stage; 0 = no scoreboard entry
fwd_valid  in  STAGES  per-stage valid
fwd_dest  in  STAGES*GPR_SIZE  packed stage destinations, stage i at [i*GPR_SIZE +: GPR_SIZE]
fwd_result  in  STAGES*DATA_SIZE  packed stage results
rd_valid  in  READ_PORTS  per-port read request
rd_addr  in  READ_PORTS*GPR_SIZE  packed read addresses
rd_operand  in  READ_PORTS*DATA_SIZE  packed register-file read data
result  out  READ_PORTS*DATA_SIZE  packed forwarded operands
stall  out  1  hold issue/read stage this cycle
busy_mask  out  NREGS  bit r = register r pending
stall_count  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (rst_n=0 at edge): all counters 0, busy_mask=0, stall_count=0.
  - stall=0 whenever no counter is nonzero; result is combinational and therefore follows the inputs.
- Scoreboard: cnt[r] (LAT_W bits) per register; pending[r] = (cnt[r]!=0); busy_mask = pending.
- Per edge, in priority order:
  - Reset clears all.
  - Else flush clears all counters; issue is ignored that cycle.
  - Else every nonzero cnt decrements by 1.
  - Then, if issue_valid && !stall && issue_latency!=0, cnt[issue_dest] <= issue_latency. Issue overrides the decrement of the same register (WAW: newest latency wins).
- ZERO_REG=1:
  - issue to register 0 is ignored.
  - A read of address 0 gives result=0 and is never pending.
  - Stages with dest 0 are never matched.
- Stall (combinational from registered cnt and current reads): stall = OR over ports p of (rd_valid[p] && pending[rd_addr[p]]).
  - An issue in cycle t affects reads only from t+1.
  - Reads with rd_valid=0 never stall.
- Forwarding per port p (combinational):
  - If the address is zero-reg, result 0.
  - Else the lowest-index stage i with fwd_valid[i] && fwd_dest[i]==rd_addr[p] supplies fwd_result[i].
  - Else rd_operand[p].
  - The result is driven even when stalling; it is don't-care to the consumer.
- stall_count increments on each edge with stall=1 and saturates at all-ones. Cleared only by reset; flush does not clear it.
- Latency: issue with latency L makes the register pending for exactly L cycles after the issuing edge. The consumer reading it at cycle t+L+1 is not stalled and must find the value in a forwarding stage.
- Reset mid-operation: all pending cleared at that edge; no residual stall.

Test Plan:
1. Reset with rst_n=0 for 2 cycles, then all reads valid -> stall=0, busy_mask=0, stall_count=0, result=rd_operand.
2. Priority: stage0 dest 5 result 0xAAAA, stage1 dest 5 result 0xBBBB, both valid, port0 reads r5 -> 0xAAAA. Drop fwd_valid[0] -> 0xBBBB. Drop both -> rd_operand.
3. Load latency: issue r3 with latency 2 at edge t, port1 reads r3 -> stall=1 for cycles t+1 and t+2, stall=0 at t+3, stall_count=2.
4. WAW/override: issue r4 latency 1, next cycle issue r4 latency 3 -> busy_mask[4] stays 1 for 3 cycles after the second issue. An issue while stall=1 -> no scoreboard change.
5. Zero register: issue r0 latency 5, read r0 with stage0 dest 0 result 0x1234 -> result=0, stall=0, busy_mask=0.
6. Flush and saturation: pend r2 and r6 then flush -> busy_mask=0 next cycle, stall drops. Force continuous stall for 2**CNT_W+3 cycles -> stall_count=0xFFFF.
